pc_fetch: RTL

//  Program counter and instruction-fetch sequencer for the SISC core.

---
 rtl/pc_fetch.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
//   Program counter and instruction-fetch sequencer for the SISC core.
//   Holds the PC and offers PC+1 to the branch address calculator. The next
//   PC is either that increment or a computed branch target. A req/ack
//   handshake fetches the instruction at the PC into the IR, which the
//   controller later commits with pc_write.
//
// Parameters
//   AW       : PC / instruction address width
//   IW       : instruction word width
//   RESET_PC : PC value loaded on reset
//   TIMEOUT  : FETCH cycles without ack before a sticky fetch error (>= 1)
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   br_addr    in   AW  branch target from the branch address calculator
//   pc_sel     in   1   1 = next PC is br_addr, 0 = next PC is pc_inc
//   pc_write   in   1   controller commits the current instruction (HOLD only)
//   flush      in   1   redirect: abandon fetch/IR, PC <= br_addr
//   imem_ack   in   1   memory returns imem_data this cycle
//   imem_data  in   IW  instruction word from memory
//   pc_out     out  AW  current PC (registered)
//   pc_inc     out  AW  pc_out + 1, wrapping at 2^AW
//   imem_req   out  1   fetch request, high only in FETCH
//   imem_addr  out  AW  fetch address, always equal to pc_out
//   ir         out  IW  instruction register
//   ir_valid   out  1   ir holds a fetched, uncommitted instruction
//   fetch_err  out  1   sticky fetch-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module pc_fetch #(
  parameter int          AW       = 16,
  parameter int          IW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int          TIMEOUT  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] br_addr,
  input  logic          pc_sel,
  input  logic          pc_write,
  input  logic          flush,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_inc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  output logic          fetch_err
);

  // The wait counter only needs to reach TIMEOUT-1.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_ERR   = 2'd3
  } state_e;

  state_e        state_q,    state_d;
  logic [AW-1:0] pc_q,       pc_d;
  logic [IW-1:0] ir_q,       ir_d;
  logic          ir_valid_q, ir_valid_d;
  logic          err_q,      err_d;
  logic [CW-1:0] cnt_q,      cnt_d;

  logic [AW-1:0] pc_plus1;

  assign pc_plus1 = pc_q + {{(AW-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    err_d      = err_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        cnt_d   = '0;
      end

      ST_FETCH: begin
        // flush outranks a same-cycle ack: the returned word belongs to the
        // abandoned address and is dropped. pc_write has no effect here.
        if (flush) begin
          pc_d  = br_addr;
          cnt_d = '0;
        end else if (imem_ack) begin
          ir_d       = imem_data;
          ir_valid_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_HOLD: begin
        if (flush) begin
          pc_d       = br_addr;
          ir_valid_d = 1'b0;
          state_d    = ST_FETCH;
        end else if (pc_write) begin
          pc_d       = pc_sel ? br_addr : pc_plus1;
          ir_valid_d = 1'b0;
          state_d    = ST_FETCH;
        end
      end

      ST_ERR: begin
        // Terminal until reset; every input is ignored.
        err_d = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc_out    = pc_q;
  assign pc_inc    = pc_plus1;
  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = err_q;

endmodule
